// File: rtl/taxi_disp_pkg.sv
// taxi_disp_pkg: shared state encoding, 7-segment glyph constants and decoder
package taxi_disp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DAY = 7'h21;
  localparam logic [6:0] SEG_NIGHT = 7'h2B;
  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    return (d < 4'd10) ? GLYPH[d] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one shift per clock
module bin2bcd_seq
  import taxi_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  bin,
  input  logic        start,
  output logic [11:0] bcd,
  output logic        done,
  output logic        busy
);
  state_t state;
  logic [9:0] sh;
  logic [11:0] acc, adj;
  logic [3:0] cnt;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
  always_comb adj = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
  // done decodes the DONE state so the consumer can latch on the same edge as bcd
  assign done = (state == DONE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      bcd <= '0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh <= bin;
          acc <= '0;
          cnt <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {acc, sh} <= {adj[10:0], sh, 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) state <= DONE;
        end
        DONE: begin
          bcd <= acc;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/taxi_fare_display.sv
// taxi_fare_display: clamps the meter fare, converts it to BCD and scans it
// onto a 4-digit common-anode display with a tariff letter on digit 3.
module taxi_fare_display
  import taxi_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter logic [9:0] FARE_MAX = 10'd999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  fare,
  input  logic        mode,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] bcd_out,
  output logic        busy
);
  localparam int W = $clog2(SCAN_DIV);
  localparam logic [W-1:0] PRE_LAST = W'(SCAN_DIV - 1);
  logic [9:0] fc, held, cap;
  logic held_valid, start, done, tick;
  logic [W-1:0] pre;
  logic [1:0] idx, nidx;
  logic [3:0] h, t, o;
  logic [6:0] glyph;
  always_comb begin
    fc = (fare > FARE_MAX) ? FARE_MAX : fare;
    start = !busy && (!held_valid || fc != held);
    tick = (pre == PRE_LAST);
    nidx = idx + 2'd1;
    {h, t, o} = bcd_out;
    glyph = (nidx == 2'd0) ? seg7_decode(o) :
            (nidx == 2'd1) ? ((h == 4'd0 && t == 4'd0) ? SEG_BLANK : seg7_decode(t)) :
            (nidx == 2'd2) ? ((h == 4'd0) ? SEG_BLANK : seg7_decode(h)) :
            (mode ? SEG_NIGHT : SEG_DAY);
  end
  bin2bcd_seq u_conv (
    .clk(clk), .rst(rst), .bin(fc), .start(start),
    .bcd(bcd_out), .done(done), .busy(busy)
  );
  // cap remembers what is being converted; held only moves once the result lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap <= '0;
      held <= '0;
      held_valid <= 1'b0;
    end else begin
      if (start) cap <= fc;
      if (done) begin
        held <= cap;
        held_valid <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= 2'd3;
      an <= 4'hF;
      seg <= SEG_BLANK;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx <= nidx;
        an <= ~(4'b0001 << nidx);
        seg <= glyph;
      end
    end
  end
endmodule

// File: tb/tb_taxi_fare_display.sv
// tb_taxi_fare_display: directed vector table plus hand sequences for
// latency, mid-conversion fare change, reset abort and a full decimal sweep.
module tb_taxi_fare_display;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mode = 1'b0;
  logic [9:0] fare = 10'd3;
  logic [6:0] seg;
  logic [3:0] an;
  logic [11:0] bcd_out;
  logic busy;
  int n_cmp = 0;
  int n_bad = 0;
  logic seg_ok = 1'b1;
  localparam logic [6:0] GL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                     7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef struct {
    logic [9:0]  fare;
    logic        mode;
    logic [11:0] bcd;
    logic [27:0] segs;
  } vec_t;
  vec_t tbl [7];

  taxi_fare_display #(.SCAN_DIV(4), .FARE_MAX(10'd999)) dut (
    .clk(clk), .rst(rst), .fare(fare), .mode(mode),
    .seg(seg), .an(an), .bcd_out(bcd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic legal(input logic [6:0] s);
    legal = (s == 7'h7F) || (s == 7'h21) || (s == 7'h2B);
    for (int i = 0; i < 10; i++) if (s == GL[i]) legal = 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!legal(seg)) seg_ok = 1'b0;
  endtask

  task automatic conv(input logic [9:0] f, input logic [11:0] exp, input string nm);
    int k;
    fare = f;
    k = 0;
    while (!busy && k < 4) begin step(); k++; end
    if (!busy) chk({nm, " start"}, busy, 1);
    k = 0;
    while (busy && k < 14) begin step(); k++; end
    if (busy) chk({nm, " finish"}, busy, 0);
    chk({nm, " bcd"}, bcd_out, exp);
  endtask

  task automatic scan_chk(input string nm, input logic [27:0] segs);
    int k;
    logic [3:0] ea;
    k = 0;
    while (an == 4'b1110 && k < 20) begin step(); k++; end
    k = 0;
    while (an != 4'b1110 && k < 20) begin step(); k++; end
    for (int d = 0; d < 4; d++) begin
      ea = ~(4'b0001 << d);
      chk($sformatf("%s an%0d", nm, d), an, ea);
      chk($sformatf("%s seg%0d", nm, d), seg, segs[d*7 +: 7]);
      if (d < 3) repeat (4) step();
    end
  endtask

  initial begin
    logic hi_ok;
    logic seen;
    logic [11:0] r;
    tbl[0] = '{10'd105,  1'b1, 12'h105, {7'h2B, 7'h79, 7'h40, 7'h12}};
    tbl[1] = '{10'd1023, 1'b0, 12'h999, {7'h21, 7'h10, 7'h10, 7'h10}};
    tbl[2] = '{10'd0,    1'b1, 12'h000, {7'h2B, 7'h7F, 7'h7F, 7'h40}};
    tbl[3] = '{10'd10,   1'b0, 12'h010, {7'h21, 7'h7F, 7'h79, 7'h40}};
    tbl[4] = '{10'd99,   1'b1, 12'h099, {7'h2B, 7'h7F, 7'h10, 7'h10}};
    tbl[5] = '{10'd700,  1'b0, 12'h700, {7'h21, 7'h78, 7'h40, 7'h40}};
    tbl[6] = '{10'd68,   1'b1, 12'h068, {7'h2B, 7'h7F, 7'h02, 7'h00}};
    // reset values
    #2 rst = 1'b1;
    #1;
    chk("rst seg", seg, 7'h7F);
    chk("rst an", an, 4'hF);
    chk("rst bcd", bcd_out, 12'h000);
    chk("rst busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // test 1: first edge after reset starts, busy seen high at E1..E11
    step();
    chk("t1 busy E0", busy, 1'b1);
    hi_ok = 1'b1;
    for (int i = 1; i <= 10; i++) begin step(); if (!busy) hi_ok = 1'b0; end
    chk("t1 busy E1..E10", hi_ok, 1'b1);
    chk("t1 bcd before E11", bcd_out, 12'h000);
    step();
    chk("t1 busy E11", busy, 1'b0);
    chk("t1 bcd E11", bcd_out, 12'h003);
    scan_chk("t1", {7'h21, 7'h7F, 7'h7F, 7'h30});
    // table of directed conversions and their display
    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].mode;
      conv(tbl[i].fare, tbl[i].bcd, $sformatf("vec%0d", i));
      scan_chk($sformatf("vec%0d", i), tbl[i].segs);
    end
    // test 3: overshoot clamps, and a steady fare causes no restart
    mode = 1'b0;
    conv(10'd1000, 12'h999, "t3");
    seen = 1'b0;
    repeat (40) begin step(); if (busy) seen = 1'b1; end
    chk("t3 no restart", seen, 1'b0);
    // test 4: fare change mid-conversion is deferred to the next idle edge
    fare = 10'd120;
    step();
    chk("t4 busy E0", busy, 1'b1);
    repeat (4) step();
    fare = 10'd121;
    repeat (6) step();
    chk("t4 bcd before E11", bcd_out, 12'h999);
    step();
    chk("t4 bcd E11", bcd_out, 12'h120);
    chk("t4 busy E11", busy, 1'b0);
    step();
    chk("t4 busy E12", busy, 1'b1);
    repeat (10) step();
    chk("t4 bcd E22", bcd_out, 12'h120);
    step();
    chk("t4 bcd E23", bcd_out, 12'h121);
    chk("t4 busy E23", busy, 1'b0);
    // test 5: reset aborts a conversion, restart afterwards
    fare = 10'd500;
    step();
    chk("t5 busy E0", busy, 1'b1);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("t5 rst bcd", bcd_out, 12'h000);
    chk("t5 rst an", an, 4'hF);
    chk("t5 rst seg", seg, 7'h7F);
    chk("t5 rst busy", busy, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("t5 restart busy", busy, 1'b1);
    repeat (10) step();
    chk("t5 busy E10", busy, 1'b1);
    step();
    chk("t5 bcd", bcd_out, 12'h500);
    chk("t5 busy E11", busy, 1'b0);
    // test 6: full sweep against a decimal reference
    for (int f = 0; f < 1000; f++) begin
      r = {4'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
      conv(10'(f), r, $sformatf("sweep %0d", f));
    end
    chk("seg always legal", seg_ok, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
